// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the instruction memory (slave).
interface fetch_stage_if #(
    parameter int IMEM_ADDR_W = 12
);
    logic [IMEM_ADDR_W-1:0] address_imem;
    logic [31:0]            q_imem;

    modport master (output address_imem, input  q_imem);
    modport slave  (input  address_imem, output q_imem);
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: program counter, instruction-memory addressing and the F/D pipeline latch.
// Optional saturating perf counters are built only when FETCH_PERF_COUNTERS_EN is defined.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter int          IMEM_ADDR_W = 12,
    parameter logic [31:0] NOP_INSN    = 32'd0
) (
    input  logic                clock,
    input  logic                reset,
    fetch_stage_if.master       imem,
    input  logic                stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output logic [31:0]         pc_out,
    output logic [31:0]         fd_insn,
    output logic [31:0]         fd_pc,
    output logic                fd_valid,
    output logic [31:0]         fetch_count,
    output logic [31:0]         stall_count,
    output logic [31:0]         flush_count
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] fd_insn_q, fd_insn_d;
    logic [31:0] fd_pc_q, fd_pc_d;
    logic        fd_valid_q, fd_valid_d;
    logic        advance;

    assign advance = !redirect && !stall;

    // Priority: redirect flushes the latch, then stall holds, otherwise advance.
    always_comb begin
        pc_d       = pc_q;
        fd_insn_d  = fd_insn_q;
        fd_pc_d    = fd_pc_q;
        fd_valid_d = fd_valid_q;
        if (redirect) begin
            pc_d       = redirect_pc;
            fd_insn_d  = NOP_INSN;
            fd_pc_d    = '0;
            fd_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d       = pc_q + 32'd1;
            fd_insn_d  = imem.q_imem;
            fd_pc_d    = pc_q + 32'd1;
            fd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            fd_insn_q  <= NOP_INSN;
            fd_pc_q    <= '0;
            fd_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            fd_insn_q  <= fd_insn_d;
            fd_pc_q    <= fd_pc_d;
            fd_valid_q <= fd_valid_d;
        end
    end

    assign imem.address_imem = pc_q[IMEM_ADDR_W-1:0];
    assign pc_out            = pc_q;
    assign fd_insn           = fd_insn_q;
    assign fd_pc             = fd_pc_q;
    assign fd_valid          = fd_valid_q;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Each counter stops at all-ones rather than wrapping.
    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (advance && fetch_count_q != '1)
            fetch_count_d = fetch_count_q + 32'd1;
        if (!redirect && stall && stall_count_q != '1)
            stall_count_d = stall_count_q + 32'd1;
        if (redirect && flush_count_q != '1)
            flush_count_d = flush_count_q + 32'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`else
    logic unused_advance;
    assign unused_advance = advance;
    assign fetch_count    = '0;
    assign stall_count    = '0;
    assign flush_count    = '0;
`endif

endmodule
